regbank_fifo_ctrl: RTL and testbench
====================================

Name: regbank_fifo_ctrl

Overview:
- Controller that runs the 10-entry x 64-bit enable-gated register bank as a circular FIFO.
- Drives the bank's one-hot write enables and selects the read entry from the bank outputs.
- Gives the bank valid/ready push and pop handshakes plus occupancy status.
- Sits between a producer and a consumer. The bank keeps its own storage; this block holds only pointers, count and flags.

Parameters:
DEPTH, 10, number of bank entries (equals bank enable width); legal range 2..16
DW, 64, data width per entry
AF_THRESH, 8, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of FIFO state
in_valid  in  1  producer has data
in_ready  out  1  FIFO can accept (= !full)
in_data  in  DW  push data
wr_en  out  DEPTH  one-hot write enable to bank en[DEPTH-1:0]
wr_data  out  DW  bank d_in; combinational copy of in_data
rd_bank  in  DEPTH*DW  packed bank outputs; entry i at [i*DW +: DW]
out_valid  out  1  head entry valid (= !empty)
out_ready  in  1  consumer takes head
out_data  out  DW  head entry: rd_bank slice at rd_ptr
count  out  clog2(DEPTH+1)  occupancy 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH

Behaviour:
- State: wr_ptr and rd_ptr (clog2(DEPTH) bits each) and count, all registered.
- Reset (reset=1 at an edge): wr_ptr=0, rd_ptr=0, count=0.
  - After reset: empty=1, full=0, in_ready=1, out_valid=0, almost_full=0, wr_en=0.
  - Reset overrides flush, push and pop.
- Handshake signals:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - in_ready depends only on registered count. No combinational path from out_ready to in_ready; no bypass when full.
- Write path:
  - wr_en = push ? (1 << wr_ptr) : 0, combinational.
  - The bank captures in_data at the same edge that wr_ptr advances.
- Write-to-read latency: data pushed at edge N appears on out_data with out_valid=1 from cycle N+1. No read latency; the bank outputs are already registered.
- Read path: out_data = rd_bank[rd_ptr*DW +: DW], combinational mux. It is a don't-care while empty; the verifier checks it only when out_valid=1.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. DEPTH need not be a power of two, so wrap uses an explicit compare.
- Count update on each non-reset, non-flush edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: count unchanged, both pointers advance.
- Full: push is blocked. Pop is allowed, and in_ready rises the next cycle.
- Empty: pop is blocked. Push is allowed, and out_valid rises the next cycle.
- Simultaneous push and pop when count==1: legal; the head is popped and the new entry becomes head.
- Flush: pointers and count go to 0 at the edge. Bank contents are left stale and are never exposed. A push or pop in the flush cycle is dropped (wr_en=0).
- Reset mid-stream: any in-flight push is discarded (wr_en=0 during reset). The bank's own reset is separate and not driven by this block.
- Invariants:
  - count never exceeds DEPTH and never goes below 0.
  - wr_en is zero or one-hot, never multi-hot.

Optional Feature:
Macro: REGBANK_FIFO_CTRL_ERR_EN
- With the macro defined:
  - Adds ports err_clr (in, 1), ovf (out, 1) and udf (out, 1).
  - ovf is a sticky flag set when in_valid=1 && full at an edge.
  - udf is a sticky flag set when out_ready=1 && empty at an edge.
  - Both flags are cleared by reset or err_clr; a set on the same edge as err_clr wins.
  - Flush does not clear them.
- Without the macro: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package regbank_pkg:
  - DEPTH_DEF=10, DW_DEF=64.
  - PTR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1).
  - Function next_ptr(ptr, depth) for the wrap rule.
- One natural sub-module: regbank_ptr, a wrapping pointer counter with inc and clr, instantiated twice for wr_ptr and rd_ptr.
- Flags, count and read mux stay in the top.

Test Plan:
- Reset then idle: empty=1, in_ready=1, out_valid=0, count=0, wr_en=0 for 5 cycles.
- Fill to full:
  - Push 10 words 0x1000_0000_0000_0000+i with out_ready=0.
  - wr_en steps 0x001 through 0x200.
  - almost_full rises after the 8th push.
  - full=1 and in_ready=0 after the 10th push.
  - An 11th in_valid produces wr_en=0 (ovf=1 when ERR_EN is defined).
- Drain: with out_ready=1, out_data returns the 10 words in order, one per cycle. empty=1 afterwards. An extra pop keeps count=0 (udf=1 when ERR_EN is defined).
- Wrap with concurrent push/pop:
  - Preload 3 words, then hold in_valid=out_ready=1 for 20 cycles.
  - count stays 3 and wr_ptr wraps 9 to 0 twice.
  - Output order matches a scoreboard.
- Flush at count=6 with in_valid=1: next cycle count=0 and empty=1, wr_en=0 in the flush cycle; the next push writes entry 0.
- Reset asserted at count=4 during a push: wr_en=0 in that cycle, and all outputs match the reset values on the following cycle.

Source files
------------

// File: rtl/regbank_pkg.sv
// ============================================================================
// regbank_pkg : shared sizes and pointer-wrap helper for the regbank FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

package regbank_pkg;

    localparam int DEPTH_DEF = 10;
    localparam int DW_DEF    = 64;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = $clog2(DEPTH_DEF + 1);

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regbank_ptr.sv
// ============================================================================
// regbank_ptr : wrapping entry pointer with increment and synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module regbank_ptr
    import regbank_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= PW'(next_ptr(32'(r_ptr), unsigned'(DEPTH)));
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/regbank_fifo_ctrl.sv
// ============================================================================
// regbank_fifo_ctrl : runs an external enable-gated register bank as a FIFO
// Optional sticky overflow/underflow flags: REGBANK_FIFO_CTRL_ERR_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module regbank_fifo_ctrl
    import regbank_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int DW        = DW_DEF,
    parameter int AF_THRESH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic [DEPTH-1:0]             wr_en,
    output logic [DW-1:0]                wr_data,
    input  logic [DEPTH*DW-1:0]          rd_bank,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full
`ifdef REGBANK_FIFO_CTRL_ERR_EN
    ,
    input  logic                         err_clr,
    output logic                         ovf,
    output logic                         udf
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT    = c_CNT_W'(AF_THRESH);

    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic               w_push;
    logic               w_pop;

    // Flags derive only from the registered count: no ready/valid bypass paths.
    assign full        = (r_count == c_DEPTH_CNT);
    assign empty       = (r_count == '0);
    assign almost_full = (r_count >= c_AF_CNT);
    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign count       = r_count;

    assign w_push = in_valid & ~full & ~flush & ~reset;
    assign w_pop  = out_ready & ~empty & ~flush & ~reset;

    assign wr_en    = w_push ? (DEPTH'(1) << w_wr_ptr) : '0;
    assign wr_data  = in_data;
    assign out_data = rd_bank[w_rd_ptr*DW +: DW];

    regbank_ptr #(
        .DEPTH (DEPTH),
        .PW    (c_PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (reset),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    regbank_ptr #(
        .DEPTH (DEPTH),
        .PW    (c_PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (reset),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef REGBANK_FIFO_CTRL_ERR_EN
    logic r_ovf;
    logic r_udf;

    // A new error on the same edge as err_clr still sets the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (in_valid & full) | (r_ovf & ~err_clr);
            r_udf <= (out_ready & empty) | (r_udf & ~err_clr);
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regbank_fifo_ctrl.sv
// ============================================================================
// tb_regbank_fifo_ctrl : table-driven + scoreboard bench with a bank model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regbank_fifo_ctrl;

    localparam int DEPTH = 10;
    localparam int DW    = 64;
    localparam int AF    = 8;
    localparam logic [63:0] BASE_FILL  = 64'h1000_0000_0000_0000;
    localparam logic [63:0] BASE_WRAP  = 64'h2000_0000_0000_0000;
    localparam logic [63:0] BASE_FLUSH = 64'h3000_0000_0000_0000;

    logic                clk;
    logic                reset;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic [DEPTH-1:0]    wr_en;
    logic [DW-1:0]       wr_data;
    logic [DEPTH*DW-1:0] rd_bank;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic [3:0]          count;
    logic                full;
    logic                empty;
    logic                almost_full;
`ifdef REGBANK_FIFO_CTRL_ERR_EN
    logic                err_clr;
    logic                ovf;
    logic                udf;
`endif

    regbank_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .DW        (DW),
        .AF_THRESH (AF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_bank     (rd_bank),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
`ifdef REGBANK_FIFO_CTRL_ERR_EN
        ,
        .err_clr     (err_clr),
        .ovf         (ovf),
        .udf         (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the enable-gated register bank.
    logic [DW-1:0] bank [DEPTH];
    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (wr_en[i]) bank[i] <= wr_data;
    end
    always_comb begin
        rd_bank = '0;
        for (int i = 0; i < DEPTH; i++)
            rd_bank[i*DW +: DW] = bank[i];
    end

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        chk_data;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic [9:0]  exp_wr_en;
        int          exp_count;
    } vec_t;

    vec_t vt [22];

    int          checks;
    int          failures;
    int          m_count;
    int          m_wr;
    logic        m_ovf;
    logic        m_udf;
    logic [63:0] sb [$];
    logic [DEPTH-1:0] w_seen;
    int          wrap_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle after a negedge, check state and combinational outputs,
    // update the reference model, then advance to the next negedge.
    task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic rs,
                         input logic [63:0] d, output logic [DEPTH-1:0] seen);
        logic exp_push;
        logic exp_pop;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        in_data   = d;
        #1;
        exp_push = iv && (m_count < DEPTH) && !fl && !rs;
        exp_pop  = ordy && (m_count > 0) && !fl && !rs;
        check("count",       64'(count),       64'(m_count));
        check("empty",       64'(empty),       64'(m_count == 0));
        check("full",        64'(full),        64'(m_count == DEPTH));
        check("in_ready",    64'(in_ready),    64'(m_count != DEPTH));
        check("out_valid",   64'(out_valid),   64'(m_count != 0));
        check("almost_full", 64'(almost_full), 64'(m_count >= AF));
        check("wr_en", 64'(wr_en), exp_push ? (64'd1 << m_wr) : 64'd0);
        if (exp_push) check("wr_data", wr_data, d);
        if (exp_pop) begin
            if (sb.size() == 0) check("sb_underrun", 64'd1, 64'd0);
            else                check("out_data", out_data, sb.pop_front());
        end
`ifdef REGBANK_FIFO_CTRL_ERR_EN
        check("ovf", 64'(ovf), 64'(m_ovf));
        check("udf", 64'(udf), 64'(m_udf));
`endif
        seen = wr_en;
        if (rs) begin
            m_count = 0; m_wr = 0; m_ovf = 1'b0; m_udf = 1'b0;
            sb.delete();
        end else begin
            m_ovf = m_ovf | (iv && m_count == DEPTH);
            m_udf = m_udf | (ordy && m_count == 0);
            if (fl) begin
                m_count = 0; m_wr = 0;
                sb.delete();
            end else begin
                if (exp_push) begin
                    sb.push_back(d);
                    m_wr = (m_wr == DEPTH - 1) ? 0 : m_wr + 1;
                end
                m_count = m_count + int'(exp_push) - int'(exp_pop);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_count = 0; m_wr = 0; m_ovf = 1'b0; m_udf = 1'b0;
        wrap_cnt = 0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
`ifdef REGBANK_FIFO_CTRL_ERR_EN
        err_clr = 1'b0;
`endif
        for (int i = 0; i < 11; i++) begin
            vt[i].iv        = 1'b1;
            vt[i].ordy      = 1'b0;
            vt[i].chk_data  = 1'b0;
            vt[i].data      = BASE_FILL + 64'(i);
            vt[i].exp_data  = '0;
            vt[i].exp_wr_en = (i < 10) ? (10'd1 << i) : 10'd0;
            vt[i].exp_count = (i < 10) ? i + 1 : 10;
        end
        for (int k = 0; k < 11; k++) begin
            vt[11+k].iv        = 1'b0;
            vt[11+k].ordy      = 1'b1;
            vt[11+k].chk_data  = (k < 10);
            vt[11+k].data      = '0;
            vt[11+k].exp_data  = BASE_FILL + 64'(k);
            vt[11+k].exp_wr_en = 10'd0;
            vt[11+k].exp_count = (k < 10) ? 9 - k : 0;
        end

        reset = 1'b1;
        repeat (2) @(negedge clk);

        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, w_seen);

        for (int i = 0; i < 22; i++) begin
            if (vt[i].chk_data) check("tbl_out_data", out_data, vt[i].exp_data);
            cycle(vt[i].iv, vt[i].ordy, 1'b0, 1'b0, vt[i].data, w_seen);
            check("tbl_wr_en", 64'(w_seen), 64'(vt[i].exp_wr_en));
            check("tbl_count", 64'(count), 64'(vt[i].exp_count));
`ifdef REGBANK_FIFO_CTRL_ERR_EN
            if (i == 10) check("ovf_after_fill", 64'(ovf), 64'd1);
            if (i == 21) check("udf_after_drain", 64'(udf), 64'd1);
`endif
        end
        check("empty_after_drain", 64'(empty), 64'd1);

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, BASE_WRAP + 64'(i), w_seen);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, BASE_WRAP + 64'(i + 3), w_seen);
            if (w_seen[DEPTH-1]) wrap_cnt++;
            check("wrap_count_hold", 64'(count), 64'd3);
        end
        check("wrap_ptr_wraps", 64'(wrap_cnt), 64'd2);

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, BASE_FLUSH + 64'(i), w_seen);
        check("pre_flush_count", 64'(count), 64'd6);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, BASE_FLUSH + 64'h10, w_seen);
        check("flush_wr_en", 64'(w_seen), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, BASE_FLUSH + 64'h20, w_seen);
        check("post_flush_wr_en", 64'(w_seen), 64'd1);

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, BASE_FLUSH + 64'h30 + 64'(i), w_seen);
        check("pre_reset_count", 64'(count), 64'd4);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, BASE_FLUSH + 64'h40, w_seen);
        check("reset_wr_en", 64'(w_seen), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_full", 64'(full), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_almost_full", 64'(almost_full), 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, w_seen);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, BASE_FLUSH + 64'h50, w_seen);
        check("post_reset_wr_en", 64'(w_seen), 64'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, w_seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
